// File: rtl/pe_arr_ctrl.sv
// Sequencer for the KSIZE*KSIZE PE array: weight load, window walk over the IFM,
// and a latency-matched delay line that tags adder-tree results with OFM addresses.
module pe_arr_ctrl #(
    parameter  int IFM_H    = 8,
    parameter  int IFM_W    = 8,
    parameter  int KSIZE    = 3,
    parameter  int STRIDE   = 1,
    parameter  int PIPE_LAT = 5,
    localparam int OH       = (IFM_H - KSIZE) / STRIDE + 1,
    localparam int OW       = (IFM_W - KSIZE) / STRIDE + 1,
    localparam int NPE      = KSIZE * KSIZE,
    localparam int WGT_W    = (NPE > 1) ? $clog2(NPE) : 1,
    localparam int ROW_W    = (IFM_H > 1) ? $clog2(IFM_H) : 1,
    localparam int COL_W    = (IFM_W > 1) ? $clog2(IFM_W) : 1,
    localparam int ADDR_W   = (OH * OW > 1) ? $clog2(OH * OW) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              wgt_load_en,
    output logic [WGT_W-1:0]  wgt_idx,
    output logic              win_valid,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic              ofm_valid,
    output logic [ADDR_W-1:0] ofm_addr
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    if (!(STRIDE == 1 || STRIDE == 2) || KSIZE > IFM_H || KSIZE > IFM_W || PIPE_LAT < 1)
    begin : g_param_check
        $error("pe_arr_ctrl: illegal STRIDE/KSIZE/PIPE_LAT parameterisation");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WGT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WGT_W-1:0]    wgt_cnt_q, wgt_cnt_d;
    logic [ROW_W-1:0]    oy_q, oy_d;
    logic [COL_W-1:0]    ox_q, ox_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic [PIPE_LAT-1:0] dv_q, dv_d;
    logic [ADDR_W-1:0]   da_q [PIPE_LAT];
    logic [ADDR_W-1:0]   da_d [PIPE_LAT];

    logic issue;
    logic last_win;

    assign issue    = (state_q == S_RUN) && !stall;
    assign last_win = (ox_q == COL_W'(OW - 1)) && (oy_q == ROW_W'(OH - 1));

    // Counters saturate on the terminal window; DONE clears them for the next layer.
    always_comb begin
        state_d   = state_q;
        wgt_cnt_d = wgt_cnt_q;
        oy_d      = oy_q;
        ox_d      = ox_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD_WGT;
                    wgt_cnt_d = '0;
                end
            end
            S_LOAD_WGT: begin
                if (wgt_cnt_q == WGT_W'(NPE - 1)) begin
                    state_d   = S_RUN;
                    wgt_cnt_d = '0;
                end else begin
                    wgt_cnt_d = wgt_cnt_q + WGT_W'(1);
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (last_win) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (ox_q == COL_W'(OW - 1)) begin
                            ox_d = '0;
                            oy_d = oy_q + ROW_W'(1);
                        end else begin
                            ox_d = ox_q + COL_W'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRN_W'(PIPE_LAT - 1)) begin
                    state_d = S_DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ox_d    = '0;
                oy_d    = '0;
                addr_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The datapath has no backpressure, so the tag line shifts every cycle.
    always_comb begin
        dv_d[0] = issue;
        da_d[0] = addr_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dv_d[i] = dv_q[i-1];
            da_d[i] = da_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            wgt_cnt_q <= '0;
            oy_q      <= '0;
            ox_q      <= '0;
            addr_q    <= '0;
            drain_q   <= '0;
            dv_q      <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                da_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wgt_cnt_q <= wgt_cnt_d;
            oy_q      <= oy_d;
            ox_q      <= ox_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            dv_q      <= dv_d;
            da_q      <= da_d;
        end
    end

    assign busy        = (state_q == S_LOAD_WGT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign wgt_load_en = (state_q == S_LOAD_WGT);
    assign wgt_idx     = wgt_cnt_q;
    assign win_valid   = issue;
    assign win_row     = (state_q == S_RUN) ? ROW_W'(int'(oy_q) * STRIDE) : '0;
    assign win_col     = (state_q == S_RUN) ? COL_W'(int'(ox_q) * STRIDE) : '0;
    assign ofm_valid   = dv_q[PIPE_LAT-1];
    assign ofm_addr    = dv_q[PIPE_LAT-1] ? da_q[PIPE_LAT-1] : '0;

endmodule

// File: tb/tb_pe_arr_ctrl.sv
// Bench for pe_arr_ctrl: three parameterisations (5x5/s1, 8x8/s2, 3x3/s1) with
// cycle-tagged expectations queued by the stimulus and popped by a negedge monitor.
module tb_pe_arr_ctrl;

    localparam int PL = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  stall_v;
    logic [15:0] cyc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    logic       busy0, done0, wen0, wv0, ov0;
    logic [3:0] widx0, addr0;
    logic [2:0] row0, col0;
    logic       busy1, done1, wen1, wv1, ov1;
    logic [3:0] widx1, addr1;
    logic [2:0] row1, col1;
    logic       busy2, done2, wen2, wv2, ov2;
    logic [3:0] widx2;
    logic [1:0] row2, col2;
    logic [0:0] addr2;

    pe_arr_ctrl #(.IFM_H(5), .IFM_W(5), .KSIZE(3), .STRIDE(1), .PIPE_LAT(PL)) u0 (
        .clk(clk), .rst_n(rst), .start(start_v[0]), .stall(stall_v[0]),
        .busy(busy0), .done(done0), .wgt_load_en(wen0), .wgt_idx(widx0),
        .win_valid(wv0), .win_row(row0), .win_col(col0),
        .ofm_valid(ov0), .ofm_addr(addr0));

    pe_arr_ctrl #(.IFM_H(8), .IFM_W(8), .KSIZE(3), .STRIDE(2), .PIPE_LAT(PL)) u1 (
        .clk(clk), .rst_n(rst), .start(start_v[1]), .stall(stall_v[1]),
        .busy(busy1), .done(done1), .wgt_load_en(wen1), .wgt_idx(widx1),
        .win_valid(wv1), .win_row(row1), .win_col(col1),
        .ofm_valid(ov1), .ofm_addr(addr1));

    pe_arr_ctrl #(.IFM_H(3), .IFM_W(3), .KSIZE(3), .STRIDE(1), .PIPE_LAT(PL)) u2 (
        .clk(clk), .rst_n(rst), .start(start_v[2]), .stall(stall_v[2]),
        .busy(busy2), .done(done2), .wgt_load_en(wen2), .wgt_idx(widx2),
        .win_valid(wv2), .win_row(row2), .win_col(col2),
        .ofm_valid(ov2), .ofm_addr(addr2));

    int         sel = 0;
    logic       m_busy, m_done, m_wen, m_wv, m_ov;
    logic [7:0] m_widx, m_row, m_col, m_addr;

    always_comb begin
        case (sel)
            1: begin
                m_busy = busy1; m_done = done1; m_wen = wen1; m_wv = wv1; m_ov = ov1;
                m_widx = 8'(widx1); m_row = 8'(row1); m_col = 8'(col1); m_addr = 8'(addr1);
            end
            2: begin
                m_busy = busy2; m_done = done2; m_wen = wen2; m_wv = wv2; m_ov = ov2;
                m_widx = 8'(widx2); m_row = 8'(row2); m_col = 8'(col2); m_addr = 8'(addr2);
            end
            default: begin
                m_busy = busy0; m_done = done0; m_wen = wen0; m_wv = wv0; m_ov = ov0;
                m_widx = 8'(widx0); m_row = 8'(row0); m_col = 8'(col0); m_addr = 8'(addr0);
            end
        endcase
    end

    // Entries are {cycle[15:0], a[7:0], b[7:0]}.
    logic [31:0] exp_wgt_q[$];
    logic [31:0] exp_win_q[$];
    logic [31:0] exp_ofm_q[$];
    logic [31:0] exp_done_q[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] pk(input int c, input int a, input int b);
        return {16'(c), 8'(a), 8'(b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s unexpected event actual=%h required=none", name, act);
    endtask

    always @(negedge clk) begin
        if (m_wen === 1'b1) begin
            if (exp_wgt_q.size() == 0) unexp("wgt", {cyc, m_widx, 8'h0});
            else chk("wgt", {cyc, m_widx, 8'h0}, exp_wgt_q.pop_front());
        end
        if (m_wv === 1'b1) begin
            if (exp_win_q.size() == 0) unexp("win", {cyc, m_row, m_col});
            else chk("win", {cyc, m_row, m_col}, exp_win_q.pop_front());
        end
        if (m_ov === 1'b1) begin
            if (exp_ofm_q.size() == 0) unexp("ofm", {cyc, m_addr, 8'h0});
            else chk("ofm", {cyc, m_addr, 8'h0}, exp_ofm_q.pop_front());
        end
        if (m_done === 1'b1) begin
            if (exp_done_q.size() == 0) unexp("done", {cyc, 16'h0});
            else chk("done", {cyc, 16'h0}, exp_done_q.pop_front());
        end
    end

    // Relative cycle 0 is the cycle start is high; stall covers relative cycles st_lo..st_hi.
    task automatic run_layer(input int s, input int st_lo, input int st_hi, input bit poke);
        int oh, ow, st, rel, k, dn, t0;
        oh  = (s == 2) ? 1 : 3;
        ow  = oh;
        st  = (s == 1) ? 2 : 1;
        sel = s;
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        t0 = int'(cyc);
        for (int i = 0; i < 9; i++) exp_wgt_q.push_back(pk(t0 + 1 + i, i, 0));
        rel = 10;
        k   = 0;
        while (k < oh * ow) begin
            if (rel >= st_lo && rel <= st_hi) begin
                rel++;
                continue;
            end
            exp_win_q.push_back(pk(t0 + rel, (k / ow) * st, (k % ow) * st));
            exp_ofm_q.push_back(pk(t0 + rel + PL, k, 0));
            k++;
            rel++;
        end
        dn = (rel - 1) + PL + 1;
        exp_done_q.push_back(pk(t0 + dn, 0, 0));
        for (int r = 1; r <= dn + 1; r++) begin
            @(posedge clk); #1;
            start_v[s] = poke && (r == 12 || r == dn);
            stall_v[s] = (r >= st_lo && r <= st_hi);
            @(negedge clk);
            chk("busy", {16'(r), 15'd0, m_busy}, {16'(r), 15'd0, (r >= 1 && r < dn)});
        end
        start_v[s] = 1'b0;
        stall_v[s] = 1'b0;
    endtask

    task automatic reset_mid_run();
        int t0;
        sel = 0;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        t0 = int'(cyc);
        for (int i = 0; i < 9; i++) exp_wgt_q.push_back(pk(t0 + 1 + i, i, 0));
        // Reset is sampled at the end of cycle 14, so window 4 is still shown in cycle 14.
        for (int k = 0; k < 5; k++) exp_win_q.push_back(pk(t0 + 10 + k, k / 3, k % 3));
        for (int r = 1; r <= 14; r++) begin
            @(posedge clk); #1;
            start_v[0] = 1'b0;
            if (r == 14) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs",
            32'({busy0, done0, wen0, widx0, wv0, row0, col0, ov0, addr0}), 32'd0);
        for (int r = 0; r < PL + 3; r++) begin
            @(negedge clk);
            chk("rst_mid_busy", {16'(r), 15'd0, m_busy}, {16'(r), 16'd0});
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        stall_v = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_u0", 32'({busy0, done0, wen0, widx0, wv0, row0, col0, ov0, addr0}), 32'd0);
        chk("rst_u1", 32'({busy1, done1, wen1, widx1, wv1, row1, col1, ov1, addr1}), 32'd0);
        chk("rst_u2", 32'({busy2, done2, wen2, widx2, wv2, row2, col2, ov2, addr2}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_layer(0, -1, -1, 1'b0);
        run_layer(0, 12, 14, 1'b0);
        run_layer(1, -1, -1, 1'b1);
        run_layer(1, -1, -1, 1'b0);
        reset_mid_run();
        run_layer(0, -1, -1, 1'b0);
        run_layer(2, -1, -1, 1'b0);

        repeat (4) @(negedge clk);
        chk("wgt_left",  32'(exp_wgt_q.size()),  32'd0);
        chk("win_left",  32'(exp_win_q.size()),  32'd0);
        chk("ofm_left",  32'(exp_ofm_q.size()),  32'd0);
        chk("done_left", 32'(exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_arr_ctrl.md
Name: pe_arr_ctrl

Overview:
Sequencer for the 9-lane PE array and adder tree (3x3 convolution datapath).
- On start, it steps through the weight-load phase, then walks a KSIZE x KSIZE window over an IFM_H x IFM_W feature map.
- Each cycle it issues one window origin to the IFM buffer and window/operand muxing.
- It tracks datapath latency and tags each result with its OFM address.
- It sits between the layer-level top controller and the PE array / feature buffers.

Parameters:
IFM_H, 8, feature-map height in pixels.
IFM_W, 8, feature-map width in pixels.
KSIZE, 3, kernel side; KSIZE*KSIZE equals the PE array size (9).
STRIDE, 1, window stride; legal values 1 or 2.
PIPE_LAT, 5, cycles from window issue to valid sum at the adder-tree output (PE multiply plus adder tree).

Ports:
clk  in  1  clock; all logic rising-edge.
rst_n  in  1  reset, synchronous, active-high (asserted = 1 resets, despite the suffix).
start  in  1  start pulse; accepted only in IDLE.
stall  in  1  IFM buffer not ready; freezes window issue.
busy  out  1  high from LOAD_WGT through DRAIN.
done  out  1  one-cycle pulse at layer completion.
wgt_load_en  out  1  weight register load strobe.
wgt_idx  out  $clog2(KSIZE*KSIZE)  PE lane index being loaded.
win_valid  out  1  window origin valid this cycle.
win_row  out  $clog2(IFM_H)  window top-left row.
win_col  out  $clog2(IFM_W)  window top-left column.
ofm_valid  out  1  adder-tree output valid this cycle.
ofm_addr  out  $clog2(OH*OW)  linear OFM address of the current result.

Behaviour:
- Derived values:
  - OH = (IFM_H-KSIZE)/STRIDE+1; OW = (IFM_W-KSIZE)/STRIDE+1 (localparams).
  - Elaboration error if STRIDE is not 1 or 2, or if KSIZE > IFM_H or KSIZE > IFM_W.
- Reset (rst_n=1 at a clock edge): state=IDLE; all outputs 0; counters and delay line cleared.
  - Reset mid-operation aborts immediately. No done pulse and no ofm_valid after reset.
- States:
  - IDLE: start=1 -> LOAD_WGT.
  - LOAD_WGT: wgt_load_en=1 and wgt_idx counts 0..KSIZE*KSIZE-1, one per cycle. After the last index -> RUN. stall is ignored in this state.
  - RUN: win_valid = !stall.
    - On each unstalled cycle, advance ox 0..OW-1, then oy 0..OH-1, row-major.
    - win_row = oy*STRIDE; win_col = ox*STRIDE.
    - The issue of (OH-1, OW-1) moves the FSM -> DRAIN.
    - Stalled cycles hold the counters, win_row and win_col; win_valid=0.
  - DRAIN: exactly PIPE_LAT cycles, counted by a drain counter -> DONE. stall is ignored.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy is ignored. start in DONE is ignored.
- Latency tracking:
  - PIPE_LAT-deep shift register of {valid, addr}, advancing every cycle regardless of stall (the datapath has no backpressure).
  - Entry addr = oy*OW+ox.
  - ofm_valid/ofm_addr at cycle t+PIPE_LAT reflect win_valid at cycle t.
- Ordering guarantee: the last ofm_valid occurs in the final DRAIN cycle; done follows one cycle later.
- No address wrap: counters saturate at terminal values, and the FSM leaves RUN on the terminal issue.
- ofm_addr is strictly increasing by 1 across ofm_valid pulses.

Test Plan:
- Reset then start at cycle 0, 5x5 map, KSIZE 3, STRIDE 1, PIPE_LAT 5, no stall:
  - wgt_idx 0..8 in cycles 1-9.
  - win_valid cycles 10-18, origins (0,0),(0,1),(0,2),(1,0)..(2,2).
  - ofm_valid cycles 15-23, addr 0..8.
  - done at cycle 24; busy high cycles 1-23.
- Same config, stall=1 during cycles 12-14:
  - win_row/win_col hold (0,2) during cycles 12-14; issue resumes at 15.
  - ofm_valid gap of 3 cycles at the matching positions; done at cycle 27.
- 8x8 map, STRIDE 2:
  - OH=OW=3, origins row/col in {0,2,4}.
  - 9 ofm_valid pulses with addr 0..8.
- start pulsed again during RUN and during DONE -> ignored; exactly one done pulse; next start from IDLE runs a full layer.
- rst_n=1 for one cycle mid-RUN (after 4 issues) -> next cycle all outputs 0, state IDLE; no stale ofm_valid emerges over the following PIPE_LAT cycles.
- Boundary, IFM 3x3, KSIZE 3:
  - single window (0,0), single ofm_valid with addr 0.
  - done exactly PIPE_LAT+1 cycles after the issue.
